// File: rtl/seg7_scan_decoder.sv
// ============================================================================
// seg7_scan_decoder
// ----------------------------------------------------------------------------
// Receive side of a multiplexed 7-segment scan bus. The scanned sel/seg lines
// are synchronized. Each dwell must stay unchanged for SETTLE_CYCLES before it
// is captured. The segment pattern is then decoded back to a hex nibble.
// A frame of NUM_DIGITS digits is assembled and offered on a valid/ready port.
//
// Optional feature macro: SEG7DEC_TIMEOUT_EN
//   When defined, adds the sticky `stall` output. It is driven by a no-scan
//   watchdog that counts cycles without a sel change.
//
// Ports:
//   clk           in   clock
//   rst           in   reset, asynchronous assert, active-low
//   sel_in        in   [2:0]  scanned digit select (asynchronous to clk)
//   seg_in        in   [7:0]  scanned segments {dp,g,f,e,d,c,b,a} (asynchronous)
//   frame_digits  out  [4*NUM_DIGITS-1:0]  digit p at [4p+3:4p]
//   frame_blank   out  [NUM_DIGITS-1:0]    bit p set: position p was all off
//   frame_valid   out  a complete frame is held on frame_digits/frame_blank
//   frame_ready   in   consumer accepts when frame_valid && frame_ready
//   code_err      out  one-cycle pulse on an undecodable captured pattern
//   err_pos       out  [2:0]  position of the most recent code_err
//   overrun       out  sticky: a frame completed while the previous one waited
//   stall         out  (SEG7DEC_TIMEOUT_EN only) sticky no-scan watchdog flag
// ============================================================================
module seg7_scan_decoder #(
   parameter int NUM_DIGITS     = 6,
   parameter int SETTLE_CYCLES  = 16,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [2:0]              sel_in,
   input  logic [7:0]              seg_in,
   output logic [4*NUM_DIGITS-1:0] frame_digits,
   output logic [NUM_DIGITS-1:0]   frame_blank,
   output logic                    frame_valid,
   input  logic                    frame_ready,
   output logic                    code_err,
   output logic [2:0]              err_pos,
`ifdef SEG7DEC_TIMEOUT_EN
   output logic                    stall,
`endif
   output logic                    overrun
);

   localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_SAT  = CNT_W'(SETTLE_CYCLES);
   localparam logic [NUM_DIGITS-1:0] ALL_SEEN = '1;

   logic                    rst_meta, rst_sync;
   logic [2:0]              sel_meta, sel_sync, sel_q;
   logic [6:0]              seg_meta, seg_sync, seg_q;
   logic [CNT_W-1:0]        stable_cnt;
   logic                    changed, capture, in_range;
   logic [6:0]              pattern;
   logic [5:0]              dec;
   logic                    dec_ok, dec_blank;
   logic [3:0]              dec_nib;
   logic [4*NUM_DIGITS-1:0] digit_sh;
   logic [NUM_DIGITS-1:0]   blank_sh;
   logic [NUM_DIGITS-1:0]   seen, seen_next;
   logic                    frame_done, accept, stall_hold;
   logic                    dp_unused;

   // The decimal point carries no digit information and never takes part
   // in change detection, so it is not brought into the clock domain.
   assign dp_unused = seg_in[7];

   // Maps an active-high g..a pattern to {ok, blank, nibble}.
   function automatic logic [5:0] decode_seg(input logic [6:0] p);
      logic [5:0] r;
      r = 6'b0;
      case (p)
         7'h3F: r = {2'b10, 4'h0};
         7'h06: r = {2'b10, 4'h1};
         7'h5B: r = {2'b10, 4'h2};
         7'h4F: r = {2'b10, 4'h3};
         7'h66: r = {2'b10, 4'h4};
         7'h6D: r = {2'b10, 4'h5};
         7'h7D: r = {2'b10, 4'h6};
         7'h07: r = {2'b10, 4'h7};
         7'h7F: r = {2'b10, 4'h8};
         7'h6F: r = {2'b10, 4'h9};
         7'h77: r = {2'b10, 4'hA};
         7'h7C: r = {2'b10, 4'hB};
         7'h39: r = {2'b10, 4'hC};
         7'h5E: r = {2'b10, 4'hD};
         7'h79: r = {2'b10, 4'hE};
         7'h71: r = {2'b10, 4'hF};
         7'h00: r = {2'b11, 4'h0};
         default: r = 6'b0;
      endcase
      return r;
   endfunction

   // Reset is asserted asynchronously but released only after two clean
   // clock edges, so no flop sees the release edge near its sample point.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rst_meta <= 1'b0;
         rst_sync <= 1'b0;
      end else begin
         rst_meta <= 1'b1;
         rst_sync <= rst_meta;
      end
   end

   // Two-flop synchronizer on the scan bus, followed by a delayed copy that
   // is used both for change detection and as the stable captured value.
   always_ff @(posedge clk or negedge rst_sync) begin
      if (!rst_sync) begin
         sel_meta <= 3'b0;
         sel_sync <= 3'b0;
         sel_q    <= 3'b0;
         seg_meta <= 7'b0;
         seg_sync <= 7'b0;
         seg_q    <= 7'b0;
      end else begin
         sel_meta <= sel_in;
         sel_sync <= sel_meta;
         sel_q    <= sel_sync;
         seg_meta <= seg_in[6:0];
         seg_sync <= seg_meta;
         seg_q    <= seg_sync;
      end
   end

   assign changed = (sel_sync != sel_q) || (seg_sync != seg_q);

   // Settle counter saturates one past the capture value, so the capture
   // strobe fires exactly once per dwell no matter how long it lasts.
   always_ff @(posedge clk or negedge rst_sync) begin
      if (!rst_sync) begin
         stable_cnt <= '0;
      end else if (changed) begin
         stable_cnt <= '0;
      end else if (stable_cnt != SETTLE_SAT) begin
         stable_cnt <= stable_cnt + CNT_W'(1);
      end
   end

   assign capture  = !changed && (stable_cnt == SETTLE_LAST);
   assign in_range = ({1'b0, sel_q} < 4'(NUM_DIGITS));
   assign pattern  = SEG_ACTIVE_LOW ? ~seg_q : seg_q;
   assign dec      = decode_seg(pattern);
   assign dec_ok    = dec[5];
   assign dec_blank = dec[4];
   assign dec_nib   = dec[3:0];

   assign frame_done = (seen == ALL_SEEN);
   assign accept     = frame_valid && frame_ready;

`ifdef SEG7DEC_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

   logic [WD_W-1:0] wd_cnt;
   logic            sel_changed;

   assign sel_changed = (sel_sync != sel_q);

   // No-scan watchdog: any synced sel movement restarts it and clears the
   // stall flag; a frozen select eventually raises stall.
   always_ff @(posedge clk or negedge rst_sync) begin
      if (!rst_sync) begin
         wd_cnt <= '0;
         stall  <= 1'b0;
      end else if (sel_changed) begin
         wd_cnt <= '0;
         stall  <= 1'b0;
      end else if (wd_cnt != WD_LIMIT) begin
         wd_cnt <= wd_cnt + WD_W'(1);
      end else begin
         stall  <= 1'b1;
      end
   end

   assign stall_hold = stall;
`else
   assign stall_hold = 1'b0;
`endif

   // Next seen mask: a completed frame clears it, but a capture landing in
   // the same cycle still marks its position for the following frame.
   always_comb begin
      seen_next = seen;
      if (frame_done) begin
         seen_next = '0;
      end
      if (capture && in_range && dec_ok) begin
         for (int p = 0; p < NUM_DIGITS; p++) begin
            if (sel_q == 3'(p)) begin
               seen_next[p] = 1'b1;
            end
         end
      end
      if (stall_hold) begin
         seen_next = '0;
      end
   end

   // Shadow buffer, error reporting and the frame handshake. Outputs are
   // only reloaded from the shadow when the consumer has room for them.
   always_ff @(posedge clk or negedge rst_sync) begin
      if (!rst_sync) begin
         digit_sh     <= '0;
         blank_sh     <= '0;
         seen         <= '0;
         frame_digits <= '0;
         frame_blank  <= '0;
         frame_valid  <= 1'b0;
         code_err     <= 1'b0;
         err_pos      <= 3'b0;
         overrun      <= 1'b0;
      end else begin
         code_err <= 1'b0;
         if (capture && in_range) begin
            if (dec_ok) begin
               for (int p = 0; p < NUM_DIGITS; p++) begin
                  if (sel_q == 3'(p)) begin
                     digit_sh[4*p +: 4] <= dec_nib;
                     blank_sh[p]        <= dec_blank;
                  end
               end
            end else begin
               code_err <= 1'b1;
               err_pos  <= sel_q;
            end
         end
         seen <= seen_next;
         if (frame_done) begin
            if (!frame_valid || accept) begin
               frame_digits <= digit_sh;
               frame_blank  <= blank_sh;
               frame_valid  <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (accept) begin
            frame_valid <= 1'b0;
         end
      end
   end

endmodule
